axi4l_mst_bridge: RTL and testbench
===================================

Name: axi4l_mst_bridge

Overview:
- AXI4-Lite master that turns the core's single-beat memory request (load/store unit side) into AXI4-Lite read or write transactions toward slaves such as the instruction RAM's AXI port, the data RAM and peripherals.
- One transaction in flight at a time.
- Returns read data, a one-cycle completion pulse and an error flag to the core.

Parameters:
- AW, 32: address width (req_addr_i, awaddr, araddr).
- DW, 32: data width (fixed 32; wstrb is DW/8 = 4 bits).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  core request valid; held by core until accepted.
- req_ready_o  out  1  bridge idle and able to accept a request.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  AW  byte address.
- req_wdata_i  in  DW  write data.
- req_wstrb_i  in  4  byte enables for writes.
- rsp_ack_o  out  1  one-cycle pulse: transaction complete.
- rsp_err_o  out  1  valid with ack: 1 if resp was SLVERR/DECERR.
- rsp_rdata_o  out  DW  read data, valid with ack; held until next read ack.
- axi_awaddr  out  AW  write address.
- axi_awprot  out  3  constant 3'b000.
- axi_awvalid  out  1  write address valid.
- axi_awready  in  1  write address ready.
- axi_wdata  out  DW  write data.
- axi_wstrb  out  4  write strobes.
- axi_wvalid  out  1  write data valid.
- axi_wready  in  1  write data ready.
- axi_bresp  in  2  write response.
- axi_bvalid  in  1  write response valid.
- axi_bready  out  1  write response ready.
- axi_araddr  out  AW  read address.
- axi_arprot  out  3  constant 3'b000.
- axi_arvalid  out  1  read address valid.
- axi_arready  in  1  read address ready.
- axi_rdata  in  DW  read data.
- axi_rresp  in  2  read response.
- axi_rvalid  in  1  read data valid.
- axi_rready  out  1  read data ready.

Behaviour:
- Reset: state IDLE.
  - All valid/ready outputs 0.
  - awaddr/araddr/wdata/rsp_rdata_o 0; wstrb 0.
  - rsp_ack_o 0, rsp_err_o 0.
  - Reset mid-transaction drops all valids immediately (asynchronous) and abandons the transaction; no ack is issued.
- Handshakes: a handshake occurs on any cycle where valid & ready.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE:
  - req_ready_o = 1 (combinational from state); all other cases 0.
  - On req_valid_i, capture addr/wdata/wstrb into output registers.
  - Write → WADDR; read → RADDR.
- WADDR:
  - awvalid and wvalid both assert on the cycle after acceptance.
  - Each deasserts independently on the cycle after its own handshake; internal aw_done/w_done flags track completion.
  - If both handshake in the same cycle, both drop together.
  - When both are done (including the same-cycle case) → WRESP.
- WRESP:
  - bready = 1.
  - On bvalid: rsp_ack_o = 1 next cycle, rsp_err_o = bresp[1], bready drops, → IDLE.
- RADDR:
  - arvalid = 1 until arready, then → RDATA.
- RDATA:
  - rready = 1.
  - On rvalid: latch rdata into rsp_rdata_o, rsp_err_o = rresp[1], rsp_ack_o pulses next cycle, → IDLE.
  - rsp_rdata_o is latched even on an error response.
- AXI rules:
  - A valid is never dependent on the corresponding ready.
  - Once asserted, a valid stays high with a stable payload until its handshake.
  - bready/rready are asserted only in WRESP/RDATA, never early.
- Latency with zero-wait slave: request accepted at cycle 0, address/data handshake at cycle 1, response at cycle 2, ack at cycle 3.
  - req_ready_o is high again in the ack cycle, so back-to-back throughput is 1 transaction per 3 cycles minimum.
- req_valid_i while not IDLE: ignored (req_ready_o=0); the core must hold the request.
- rsp_err_o is 0 when rsp_ack_o is 0.
- Unaligned addresses are passed unchanged; the slave word-aligns them.

Test Plan:
- Write, zero-wait slave, addr 0x0000_0010, wdata 0xA5A5_1234, wstrb 0xF → awvalid/wvalid high 1 cycle, bready high 1 cycle, ack at cycle 3, err=0, slave memory holds 0xA5A5_1234.
- Read of the same address with 3-cycle rvalid delay → arvalid 1 cycle, rready held 3 cycles, ack with rsp_rdata_o=0xA5A5_1234, err=0.
- Write where wready arrives 2 cycles before awready → wvalid drops after its handshake, awvalid stays high with stable awaddr, exactly one B handshake, one ack.
- Slave returns rresp=2'b10 → ack with err=1 and rdata latched; next transaction returns err=0.
- Request held during a busy state plus rst_n pulse mid-RDATA → req_ready_o=0 while busy; all valids 0 during reset, no ack emitted, IDLE with req_ready_o=1 after reset release.
- Random stalls on all five channels, 1000 mixed transactions → protocol checker clean (valid stability, no valid drop), scoreboard matches every read.

Source files
------------

// File: rtl/axi4l_mst_bridge.sv
// ---------------------------------------------------------------------------
// axi4l_mst_bridge
//
// Turns a single-beat memory request from the core (load/store side) into an
// AXI4-Lite read or write transaction. Only one transaction is in flight at a
// time. Completion is reported with a one-cycle ack pulse, an error flag
// (SLVERR/DECERR) and, for reads, the returned data.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid_i          core request valid, held until accepted
//   req_ready_o          bridge idle, request accepted when both are high
//   req_we_i             1 = write, 0 = read
//   req_addr_i           byte address, passed unchanged to the bus
//   req_wdata_i          write data
//   req_wstrb_i          write byte enables
//   rsp_ack_o            one-cycle completion pulse
//   rsp_err_o            error flag, meaningful only with rsp_ack_o
//   rsp_rdata_o          read data, held until the next read completes
//   axi_aw* / axi_w*     write address / write data channels
//   axi_b*               write response channel
//   axi_ar* / axi_r*     read address / read data channels
// ---------------------------------------------------------------------------
module axi4l_mst_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [DW-1:0]   req_wdata_i,
    input  logic [DW/8-1:0] req_wstrb_i,

    output logic            rsp_ack_o,
    output logic            rsp_err_o,
    output logic [DW-1:0]   rsp_rdata_o,

    output logic [AW-1:0]   axi_awaddr,
    output logic [2:0]      axi_awprot,
    output logic            axi_awvalid,
    input  logic            axi_awready,

    output logic [DW-1:0]   axi_wdata,
    output logic [DW/8-1:0] axi_wstrb,
    output logic            axi_wvalid,
    input  logic            axi_wready,

    input  logic [1:0]      axi_bresp,
    input  logic            axi_bvalid,
    output logic            axi_bready,

    output logic [AW-1:0]   axi_araddr,
    output logic [2:0]      axi_arprot,
    output logic            axi_arvalid,
    input  logic            axi_arready,

    input  logic [DW-1:0]   axi_rdata,
    input  logic [1:0]      axi_rresp,
    input  logic            axi_rvalid,
    output logic            axi_rready
);

    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic            awvalid_r;
    logic            aw_done_r;
    logic [AW-1:0]   awaddr_r;
    logic            wvalid_r;
    logic            w_done_r;
    logic [DW-1:0]   wdata_r;
    logic [SW-1:0]   wstrb_r;
    logic            arvalid_r;
    logic [AW-1:0]   araddr_r;
    logic            bready_r;
    logic            rready_r;
    logic            rsp_ack_r;
    logic            rsp_err_r;
    logic [DW-1:0]   rsp_rdata_r;

    logic            req_acc_s;
    logic            aw_hs_s;
    logic            w_hs_s;
    logic            b_hs_s;
    logic            ar_hs_s;
    logic            r_hs_s;
    logic            wr_both_done_s;
    logic            unused_resp_s;

    // Handshake decode; every valid/ready here is a flop or a bus input.
    assign req_acc_s = req_valid_i & (state_r == ST_IDLE);
    assign aw_hs_s   = awvalid_r & axi_awready;
    assign w_hs_s    = wvalid_r  & axi_wready;
    assign b_hs_s    = bready_r  & axi_bvalid;
    assign ar_hs_s   = arvalid_r & axi_arready;
    assign r_hs_s    = rready_r  & axi_rvalid;

    // Address and data phases may complete in either order or together.
    assign wr_both_done_s = (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);

    // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    assign unused_resp_s = axi_bresp[0] ^ axi_rresp[0];

    // Next-state decode for the transaction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_we_i) begin
                        state_nxt_s = ST_WADDR;
                    end else begin
                        state_nxt_s = ST_RADDR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WADDR: begin
                if (wr_both_done_s) begin
                    state_nxt_s = ST_WRESP;
                end else begin
                    state_nxt_s = ST_WADDR;
                end
            end
            ST_WRESP: begin
                if (b_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRESP;
                end
            end
            ST_RADDR: begin
                if (ar_hs_s) begin
                    state_nxt_s = ST_RDATA;
                end else begin
                    state_nxt_s = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (r_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RDATA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write address channel: valid rises on acceptance, drops after its own handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b0;
            awaddr_r  <= {AW{1'b0}};
        end else if (req_acc_s && req_we_i) begin
            awvalid_r <= 1'b1;
            aw_done_r <= 1'b0;
            awaddr_r  <= req_addr_i;
        end else if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
        end else begin
            awvalid_r <= awvalid_r;
            aw_done_r <= aw_done_r;
        end
    end

    // Write data channel: independent of the address channel's progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b0;
            wdata_r  <= {DW{1'b0}};
            wstrb_r  <= {SW{1'b0}};
        end else if (req_acc_s && req_we_i) begin
            wvalid_r <= 1'b1;
            w_done_r <= 1'b0;
            wdata_r  <= req_wdata_i;
            wstrb_r  <= req_wstrb_i;
        end else if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
        end else begin
            wvalid_r <= wvalid_r;
            w_done_r <= w_done_r;
        end
    end

    // Read address channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_r <= 1'b0;
            araddr_r  <= {AW{1'b0}};
        end else if (req_acc_s && !req_we_i) begin
            arvalid_r <= 1'b1;
            araddr_r  <= req_addr_i;
        end else if (ar_hs_s) begin
            arvalid_r <= 1'b0;
        end else begin
            arvalid_r <= arvalid_r;
        end
    end

    // Response-channel readies track the response-wait states exactly, so
    // they are never raised before the request phase has finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bready_r <= 1'b0;
            rready_r <= 1'b0;
        end else begin
            bready_r <= (state_nxt_s == ST_WRESP);
            rready_r <= (state_nxt_s == ST_RDATA);
        end
    end

    // Completion pulse and error flag; error is forced low outside the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ack_r <= 1'b0;
            rsp_err_r <= 1'b0;
        end else if (b_hs_s) begin
            rsp_ack_r <= 1'b1;
            rsp_err_r <= axi_bresp[1];
        end else if (r_hs_s) begin
            rsp_ack_r <= 1'b1;
            rsp_err_r <= axi_rresp[1];
        end else begin
            rsp_ack_r <= 1'b0;
            rsp_err_r <= 1'b0;
        end
    end

    // Read data is captured even on an error response and held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_r <= {DW{1'b0}};
        end else if (r_hs_s) begin
            rsp_rdata_r <= axi_rdata;
        end else begin
            rsp_rdata_r <= rsp_rdata_r;
        end
    end

    assign req_ready_o = (state_r == ST_IDLE);
    assign rsp_ack_o   = rsp_ack_r;
    assign rsp_err_o   = rsp_err_r;
    assign rsp_rdata_o = rsp_rdata_r;

    assign axi_awaddr  = awaddr_r;
    assign axi_awprot  = 3'b000;
    assign axi_awvalid = awvalid_r;
    assign axi_wdata   = wdata_r;
    assign axi_wstrb   = wstrb_r;
    assign axi_wvalid  = wvalid_r;
    assign axi_bready  = bready_r;
    assign axi_araddr  = araddr_r;
    assign axi_arprot  = 3'b000;
    assign axi_arvalid = arvalid_r;
    assign axi_rready  = rready_r;

endmodule

// File: tb/tb_axi4l_mst_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi4l_mst_bridge
//
// Directed and randomised-stall stimulus for axi4l_mst_bridge against a
// configurable AXI4-Lite slave with a 64-word memory. Expected responses are
// queued when a request is accepted and compared by a monitor whenever the
// bridge pulses rsp_ack_o. The same monitor watches channel rules (valid
// stability, drop after handshake, ready only in response phases).
// ---------------------------------------------------------------------------
module tb_axi4l_mst_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready_o;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic [3:0]    req_wstrb = 4'h0;
    logic          rsp_ack_o;
    logic          rsp_err_o;
    logic [31:0]   rsp_rdata_o;
    logic [31:0]   axi_awaddr;
    logic [2:0]    axi_awprot;
    logic          axi_awvalid;
    logic          axi_awready;
    logic [31:0]   axi_wdata;
    logic [3:0]    axi_wstrb;
    logic          axi_wvalid;
    logic          axi_wready;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready;
    logic [31:0]   axi_araddr;
    logic [2:0]    axi_arprot;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [31:0]   axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rvalid;
    logic          axi_rready;

    always #5 clk = ~clk;

    axi4l_mst_bridge #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_ack_o(rsp_ack_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_acks = 0;
    int ack_cnt = 0;
    int wr_acked = 0;
    int b_hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_q, w_q, r_q;
    logic [3:0]  ws_q;
    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic [31:0] shadow [0:63] = '{default: 32'h0};

    logic        s_aw_hs, s_w_hs, s_ar_hs, s_r_hs, s_b_hs, wr_fire;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    assign axi_awready = axi_awvalid && (aw_cnt >= aw_dly);
    assign axi_wready  = axi_wvalid  && (w_cnt  >= w_dly);
    assign axi_arready = axi_arvalid && (ar_cnt >= ar_dly);
    assign axi_bvalid  = b_pend && (b_cnt >= b_dly);
    assign axi_rvalid  = r_pend && (r_cnt >= r_dly);
    assign axi_bresp   = b_resp_cfg;
    assign axi_rresp   = r_resp_cfg;
    assign axi_rdata   = r_q;

    assign s_aw_hs = axi_awvalid & axi_awready;
    assign s_w_hs  = axi_wvalid  & axi_wready;
    assign s_ar_hs = axi_arvalid & axi_arready;
    assign s_r_hs  = axi_rvalid  & axi_rready;
    assign s_b_hs  = axi_bvalid  & axi_bready;
    assign wr_addr = s_aw_hs ? axi_awaddr : aw_q;
    assign wr_data = s_w_hs  ? axi_wdata  : w_q;
    assign wr_strb = s_w_hs  ? axi_wstrb  : ws_q;
    assign wr_fire = (aw_got | s_aw_hs) & (w_got | s_w_hs);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_q <= 32'h0; w_q <= 32'h0; ws_q <= 4'h0; r_q <= 32'h0;
        end else begin
            if (s_aw_hs) aw_cnt <= 0; else if (axi_awvalid) aw_cnt <= aw_cnt + 1;
            if (s_w_hs)  w_cnt  <= 0; else if (axi_wvalid)  w_cnt  <= w_cnt + 1;
            if (s_ar_hs) ar_cnt <= 0; else if (axi_arvalid) ar_cnt <= ar_cnt + 1;
            if (s_aw_hs) aw_q <= axi_awaddr;
            if (s_w_hs) begin w_q <= axi_wdata; ws_q <= axi_wstrb; end
            if (wr_fire) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end else begin
                if (s_aw_hs) aw_got <= 1'b1;
                if (s_w_hs)  w_got  <= 1'b1;
                if (s_b_hs) b_pend <= 1'b0;
                else if (b_pend && !axi_bvalid) b_cnt <= b_cnt + 1;
            end
            if (s_ar_hs) begin
                r_pend <= 1'b1; r_cnt <= 0; r_q <= mem[axi_araddr[7:2]];
            end else if (s_r_hs) begin
                r_pend <= 1'b0;
            end else if (r_pend && !axi_rvalid) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && wr_fire) mem[wr_addr[7:2]] <= merge(mem[wr_addr[7:2]], wr_data, wr_strb);
        if (rst_n && s_b_hs) b_hs_cnt <= b_hs_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        bit          rd;
        bit          err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
        int          n_aw, n_w, n_b, n_ar, n_r;
    } exp_t;

    exp_t sb[$];

    // Monitor: channel rules every cycle, response comparison on each ack.
    initial begin
        exp_t        e;
        logic        p_rst = 1'b0, p_ack = 1'b0;
        logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
        logic [31:0] p_awa = 32'h0, p_wd = 32'h0, p_ara = 32'h0;
        logic [3:0]  p_ws = 4'h0;
        logic [31:0] last_rd = 32'h0;
        int          c_aw = 0, c_w = 0, c_b = 0, c_ar = 0, c_r = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_rst = 1'b0; last_rd = 32'h0;
                c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
            end else begin
                if (p_rst) begin
                    if (p_awv && !p_awr && (!axi_awvalid || axi_awaddr !== p_awa)) begin
                        fails++; $display("FAIL aw_stable: awvalid=%0b awaddr=0x%0h, want 1/0x%0h", axi_awvalid, axi_awaddr, p_awa);
                    end
                    if (p_wv && !p_wr && (!axi_wvalid || axi_wdata !== p_wd || axi_wstrb !== p_ws)) begin
                        fails++; $display("FAIL w_stable: wvalid=%0b wdata=0x%0h wstrb=0x%0h, want 1/0x%0h/0x%0h", axi_wvalid, axi_wdata, axi_wstrb, p_wd, p_ws);
                    end
                    if (p_arv && !p_arr && (!axi_arvalid || axi_araddr !== p_ara)) begin
                        fails++; $display("FAIL ar_stable: arvalid=%0b araddr=0x%0h, want 1/0x%0h", axi_arvalid, axi_araddr, p_ara);
                    end
                    if (p_awv && p_awr && axi_awvalid) begin fails++; $display("FAIL aw_drop: awvalid=1 after handshake, want 0"); end
                    if (p_wv && p_wr && axi_wvalid)    begin fails++; $display("FAIL w_drop: wvalid=1 after handshake, want 0"); end
                    if (p_arv && p_arr && axi_arvalid) begin fails++; $display("FAIL ar_drop: arvalid=1 after handshake, want 0"); end
                    if (p_ack && rsp_ack_o)            begin fails++; $display("FAIL ack_pulse: ack high 2 cycles, want 1"); end
                end
                if (axi_bready && (axi_awvalid || axi_wvalid || axi_arvalid || axi_rready)) begin
                    fails++; $display("FAIL bready_early: bready=1 with other channel active");
                end
                if (axi_rready && (axi_arvalid || axi_awvalid || axi_wvalid)) begin
                    fails++; $display("FAIL rready_early: rready=1 with request channel active");
                end
                if (!rsp_ack_o && rsp_err_o) begin fails++; $display("FAIL err_no_ack: err=1 with ack=0, want 0"); end
                if (axi_awprot !== 3'b000 || axi_arprot !== 3'b000) begin
                    fails++; $display("FAIL prot: awprot=%0d arprot=%0d, want 0/0", axi_awprot, axi_arprot);
                end
                if (axi_awvalid) c_aw++;
                if (axi_wvalid)  c_w++;
                if (axi_bready)  c_b++;
                if (axi_arvalid) c_ar++;
                if (axi_rready)  c_r++;
                if (rsp_ack_o) begin
                    ack_cnt++;
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_ack: ack=1 with no outstanding request, want 0");
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, " err"}, rsp_err_o, e.err);
                        if (e.rd) begin
                            chk({e.name, " rdata"}, rsp_rdata_o, e.rdata);
                            last_rd = e.rdata;
                        end else begin
                            chk({e.name, " rdata_hold"}, rsp_rdata_o, last_rd);
                            wr_acked++;
                        end
                        if (e.lat > 0)   chk({e.name, " latency"}, cyc - e.acc, e.lat);
                        if (e.n_aw >= 0) chk({e.name, " awvalid_cycles"}, c_aw, e.n_aw);
                        if (e.n_w >= 0)  chk({e.name, " wvalid_cycles"}, c_w, e.n_w);
                        if (e.n_b >= 0)  chk({e.name, " bready_cycles"}, c_b, e.n_b);
                        if (e.n_ar >= 0) chk({e.name, " arvalid_cycles"}, c_ar, e.n_ar);
                        if (e.n_r >= 0)  chk({e.name, " rready_cycles"}, c_r, e.n_r);
                    end
                    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
                end
                p_rst = 1'b1;
            end
            p_ack = rsp_ack_o;
            p_awv = axi_awvalid; p_awr = axi_awready; p_awa = axi_awaddr;
            p_wv  = axi_wvalid;  p_wr  = axi_wready;  p_wd  = axi_wdata; p_ws = axi_wstrb;
            p_arv = axi_arvalid; p_arr = axi_arready; p_ara = axi_araddr;
        end
    end

    // Wait for an idle bridge, present one request, queue its expected response.
    task automatic issue(input string nm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [1:0] resp,
                         input logic [31:0] exp_rd, input bit use_model, input int lat,
                         input int d_aw, input int d_w, input int d_b, input int d_ar, input int d_r,
                         input int n_aw, input int n_w, input int n_b, input int n_ar, input int n_r);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " req_ready"}, req_ready_o, 1);
        if (!req_ready_o) return;
        aw_dly = d_aw; w_dly = d_w; b_dly = d_b; ar_dly = d_ar; r_dly = d_r;
        b_resp_cfg = resp; r_resp_cfg = resp;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        e.name = nm; e.rd = !we; e.err = resp[1]; e.lat = lat; e.acc = cyc;
        e.n_aw = n_aw; e.n_w = n_w; e.n_b = n_b; e.n_ar = n_ar; e.n_r = n_r;
        if (we) begin
            shadow[addr[7:2]] = merge(shadow[addr[7:2]], wd, ws);
            e.rdata = 32'h0;
        end else begin
            e.rdata = use_model ? shadow[addr[7:2]] : exp_rd;
        end
        @(posedge clk);
        #1;
        sb.push_back(e);
        exp_acks++;
        req_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          we, idx, off, rnd;
        logic [31:0] a;
        logic [1:0]  rs;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset awvalid", axi_awvalid, 0);
        chk("reset wvalid", axi_wvalid, 0);
        chk("reset arvalid", axi_arvalid, 0);
        chk("reset bready/rready", {axi_bready, axi_rready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", req_ready_o, 1);
        chk("post-reset ack/err", {rsp_ack_o, rsp_err_o}, 0);
        chk("post-reset addrs", {axi_awaddr, axi_araddr}, 0);
        chk("post-reset wdata/wstrb", {axi_wdata, axi_wstrb}, 0);
        chk("post-reset rdata", rsp_rdata_o, 0);

        //     name        we  addr          wdata         strb  resp   exp_rd        mdl lat  aw w  b  ar r   naw nw nb nar nr
        issue("wr_zero",   1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 2'b00, 32'h0,        0,  3,  0, 0, 0, 0, 0,  1, 1, 1, 0, 0);
        issue("rd_delay",  0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hA5A5_1234, 0, 5,  0, 0, 0, 0, 2,  0, 0, 0, 1, 3);
        issue("wr_w_first",1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0,        0,  5,  2, 0, 0, 0, 0,  3, 1, 1, 0, 0);
        issue("wr_partial",1, 32'h0000_0010, 32'h1122_3344, 4'h5, 2'b00, 32'h0,        0,  3,  0, 0, 0, 0, 0,  1, 1, 1, 0, 0);
        issue("rd_unalign",0, 32'h0000_0012, 32'h0,         4'h0, 2'b00, 32'hA522_1244, 0, 3,  0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        issue("rd_slverr", 0, 32'h0000_0020, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEEF, 0, 3,  0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        issue("rd_ok_next",0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hA522_1244, 0, 6,  0, 0, 0, 2, 1,  0, 0, 0, 3, 2);
        issue("wr_decerr", 1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 2'b11, 32'h0,        0,  8,  1, 3, 2, 0, 0,  2, 4, 3, 0, 0);
        issue("wr_exokay", 1, 32'h0000_0034, 32'h1234_5678, 4'hF, 2'b01, 32'h0,        0,  3,  0, 0, 0, 0, 0,  1, 1, 1, 0, 0);
        issue("rd_30",     0, 32'h0000_0030, 32'h0,         4'h0, 2'b00, 32'h0BAD_F00D, 0, 3,  0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        issue("rd_34",     0, 32'h0000_0034, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 0, 3,  0, 0, 0, 0, 0,  0, 0, 0, 1, 1);

        // Busy-hold and reset in the middle of a read data wait
        issue("rd_abandon",0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hA522_1244, 0, 0,  0, 0, 0, 0, 20, -1, -1, -1, -1, -1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("busy req_ready", req_ready_o, 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-reset valids", {axi_awvalid, axi_wvalid, axi_arvalid}, 0);
        chk("mid-reset readies", {axi_bready, axi_rready}, 0);
        chk("mid-reset ack", rsp_ack_o, 0);
        chk("mid-reset rdata", rsp_rdata_o, 0);
        exp_acks = exp_acks - sb.size();
        sb.delete();
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after-reset req_ready", req_ready_o, 1);
        chk("after-reset ack", rsp_ack_o, 0);
        repeat (3) @(negedge clk);

        // Mixed traffic with random stalls on every channel
        for (int i = 0; i < 1000; i++) begin
            we  = $urandom_range(0, 1);
            idx = $urandom_range(0, 63);
            off = $urandom_range(0, 3);
            rnd = $urandom_range(0, 3);
            a   = 32'h0;
            a[7:2] = idx[5:0];
            a[1:0] = off[1:0];
            rs = 2'b00;
            rs[0] = rnd[0];
            if ($urandom_range(0, 3) == 0) rs[1] = 1'b1;
            issue($sformatf("rnd%0d", i), we[0], a, $urandom, 4'($urandom_range(0, 15)), rs,
                  32'h0, 1, 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  -1, -1, -1, -1, -1);
        end

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain outstanding", sb.size(), 0);
        chk("ack count", ack_cnt, exp_acks);
        chk("b handshake count", b_hs_cnt, wr_acked);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
